jtframe_z80wait: RTL and testbench
==================================

JTFRAME_Z80WAIT -- requirements
Module: jtframe_z80wait

Interface
REQ-001 SHALL have parameter DEVCNT, default 2, number of SDRAM-backed devices that may stall the CPU.
REQ-002 SHALL have parameter RECOVERY, default 1, 1 = repay clock enables lost during stalls, 0 = lost enables are dropped.
REQ-003 SHALL have parameter CNTW, default 4, width of the lost-enable debt counter.
REQ-004 SHALL have parameter M1WAIT, default 0 (range 0-3), extra stalled enables on every opcode fetch.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port clk  input  1  system clock; the only clock.
REQ-007 SHALL have port cen_in  input  1  nominal CPU clock enable.
REQ-008 SHALL have port m1_n  input  1  CPU opcode-fetch strobe.
REQ-009 SHALL have port mreq_n  input  1  CPU memory request.
REQ-010 SHALL have port busak_n  input  1  CPU bus acknowledge; low = CPU off bus.
REQ-011 SHALL have port rom_cs  input  DEVCNT  per-device chip select.
REQ-012 SHALL have port rom_ok  input  DEVCNT  per-device data valid.
REQ-013 SHALL have port dev_busy  input  DEVCNT  per-device arbitration busy; stalls regardless of rom_cs.
REQ-014 SHALL have port cpu_cen  output  1  gated enable to the CPU core.
REQ-015 SHALL have port stall  output  1  high while any stall condition holds (debug).

Function
REQ-016 SHALL register rom_cs each clk as cs_l; device i SHALL be pending when rom_cs[i] & (~rom_ok[i] | ~cs_l[i]), so a stale rom_ok in the first rom_cs cycle never releases the CPU.
REQ-017 SHALL define stall = busak_n & (|pending | |dev_busy | m1cnt!=0), combinational from inputs and registered state.
REQ-018 SHALL load m1cnt with M1WAIT in the clk where ~m1_n & ~mreq_n first becomes true (rising edge of the registered fetch flag); m1cnt SHALL decrement by 1 on each cen_in while non-zero.
REQ-019 SHALL not load m1cnt when M1WAIT=0; interrupt acknowledge (m1_n low, mreq_n high) SHALL not load it.
REQ-020 SHALL drive cpu_cen = cen_in & ~stall, or 1 on a recovery cycle (REQ-022); cpu_cen is combinational, zero latency from cen_in.
REQ-021 SHALL increment debt (saturating at 2^CNTW-1) on each clk with cen_in & stall when RECOVERY=1; debt SHALL remain 0 when RECOVERY=0.
REQ-022 A recovery cycle SHALL occur when cen_in=0, stall=0, debt!=0 and the previous clk's cpu_cen=0; debt SHALL decrement by 1 on it.
REQ-023 SHALL never assert cpu_cen on two consecutive clk cycles due to recovery (minimum 2-clk CPU period); cen_in-driven back-to-back pulses pass unchanged.
REQ-024 SHALL, when cen_in & stall and a recovery condition coincide, take no recovery; debt +1 only.
REQ-025 SHALL, while busak_n=0, force stall=0 and hold debt (no increment, recovery still allowed).
REQ-026 SHALL treat each device independently; release requires every pending device to clear.

Reset
REQ-027 SHALL, while rst=1, clear debt, m1cnt, cs_l, fetch flag and previous-cpu_cen register, and force cpu_cen=0 and stall=0.
REQ-028 SHALL, on rst deassertion mid-stall, restart with debt=0 and re-evaluate pending from the first clk (cs_l=0, so any asserted rom_cs is pending for one clk).

Verification
REQ-029 SHALL cover: cen_in every 4th clk, rom_cs[0] rising with rom_ok[0] already 1 -> cpu_cen suppressed in first cycle, stall=1 for exactly 1 clk.
REQ-030 SHALL cover: rom_ok[0] low across 3 cen_in pulses, RECOVERY=1 -> debt reaches 3, then 3 extra cpu_cen pulses in following cen_in-free clks, none adjacent; total pulse count equals cen_in count.
REQ-031 SHALL cover: same stimulus, RECOVERY=0 -> exactly 3 cpu_cen pulses lost, debt stays 0.
REQ-032 SHALL cover: M1WAIT=2, opcode fetch -> first 2 cen_in after fetch start suppressed, third passes; INTA cycle -> no suppression.
REQ-033 SHALL cover: stall held for 20 cen_in with CNTW=4 -> debt saturates at 15, exactly 15 repaid.
REQ-034 SHALL cover: rst asserted with debt=5 -> cpu_cen=0 during rst, no recovery pulses after release.

Source files
------------

// File: rtl/jtframe_z80wait.sv
// Z80 clock-enable gating: holds the CPU while SDRAM-backed devices are not ready,
// optionally adds opcode-fetch wait states and repays enables lost during stalls.
module jtframe_z80wait #(
    parameter int DEVCNT   = 2,
    parameter int RECOVERY = 1,
    parameter int CNTW     = 4,
    parameter int M1WAIT   = 0
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen_in,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              busak_n,
    input  logic [DEVCNT-1:0] rom_cs,
    input  logic [DEVCNT-1:0] rom_ok,
    input  logic [DEVCNT-1:0] dev_busy,
    output logic              cpu_cen,
    output logic              stall
);

    localparam logic [CNTW-1:0] DEBT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] DEBT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] DEBT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [1:0]      M1_LOAD   = 2'(M1WAIT);
    localparam logic            REC_EN    = (RECOVERY != 0);
    localparam logic            M1_EN     = (M1WAIT != 0);

    logic [DEVCNT-1:0] cs_l_q, cs_l_d;
    logic              fetch_q, fetch_d;
    logic              prev_cen_q, prev_cen_d;
    logic [1:0]        m1cnt_q, m1cnt_d;
    logic [CNTW-1:0]   debt_q, debt_d;

    logic [DEVCNT-1:0] pending_s;
    logic              fetch_s;
    logic              fetch_rise_s;
    logic              raw_stall_s;
    logic              recover_s;

    // Stall decision and gated CPU enable; a stale rom_ok in the first cs cycle is ignored.
    always_comb begin
        pending_s    = rom_cs & (~rom_ok | ~cs_l_q);
        fetch_s      = ~m1_n & ~mreq_n;
        fetch_rise_s = fetch_s & ~fetch_q;
        raw_stall_s  = busak_n & ((|pending_s) | (|dev_busy) | (m1cnt_q != 2'd0));
        recover_s    = REC_EN & ~rst & ~cen_in & ~raw_stall_s
                     & (debt_q != DEBT_ZERO) & ~prev_cen_q;
        if (rst) begin
            stall   = 1'b0;
            cpu_cen = 1'b0;
        end else begin
            stall   = raw_stall_s;
            cpu_cen = (cen_in & ~raw_stall_s) | recover_s;
        end
    end

    // Next-state for the fetch wait counter and the lost-enable debt.
    always_comb begin
        cs_l_d     = rom_cs;
        fetch_d    = fetch_s;
        prev_cen_d = cpu_cen;
        m1cnt_d    = m1cnt_q;
        debt_d     = debt_q;

        if (M1_EN && fetch_rise_s) begin
            m1cnt_d = M1_LOAD;
        end else if (cen_in && (m1cnt_q != 2'd0)) begin
            m1cnt_d = m1cnt_q - 2'd1;
        end else begin
            m1cnt_d = m1cnt_q;
        end

        // busak_n low already clears raw_stall_s, so the debt simply holds then
        if (REC_EN && cen_in && raw_stall_s) begin
            if (debt_q != DEBT_MAX) begin
                debt_d = debt_q + DEBT_ONE;
            end else begin
                debt_d = debt_q;
            end
        end else if (recover_s) begin
            debt_d = debt_q - DEBT_ONE;
        end else begin
            debt_d = debt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_l_q     <= {DEVCNT{1'b0}};
            fetch_q    <= 1'b0;
            prev_cen_q <= 1'b0;
            m1cnt_q    <= 2'd0;
            debt_q     <= DEBT_ZERO;
        end else begin
            cs_l_q     <= cs_l_d;
            fetch_q    <= fetch_d;
            prev_cen_q <= prev_cen_d;
            m1cnt_q    <= m1cnt_d;
            debt_q     <= debt_d;
        end
    end

endmodule

// File: tb/tb_jtframe_z80wait.sv
// Scoreboard bench for jtframe_z80wait: three configurations share stimulus and are
// compared every clock against a rule-level reference model.
module tb_jtframe_z80wait;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen_in = 1'b0;
    logic       m1_n = 1'b1;
    logic       mreq_n = 1'b1;
    logic       busak_n = 1'b1;
    logic [1:0] rom_cs = 2'b00;
    logic [1:0] rom_ok = 2'b00;
    logic [1:0] dev_busy = 2'b00;
    logic [2:0] cen_v;
    logic [2:0] st_v;

    always #5 clk = ~clk;

    // a: RECOVERY=1 M1WAIT=0, b: RECOVERY=0, c: RECOVERY=1 M1WAIT=2
    jtframe_z80wait #(.DEVCNT(2), .RECOVERY(1), .CNTW(4), .M1WAIT(0)) dut_a (
        .rst(rst), .clk(clk), .cen_in(cen_in), .m1_n(m1_n), .mreq_n(mreq_n),
        .busak_n(busak_n), .rom_cs(rom_cs), .rom_ok(rom_ok), .dev_busy(dev_busy),
        .cpu_cen(cen_v[0]), .stall(st_v[0]));
    jtframe_z80wait #(.DEVCNT(2), .RECOVERY(0), .CNTW(4), .M1WAIT(0)) dut_b (
        .rst(rst), .clk(clk), .cen_in(cen_in), .m1_n(m1_n), .mreq_n(mreq_n),
        .busak_n(busak_n), .rom_cs(rom_cs), .rom_ok(rom_ok), .dev_busy(dev_busy),
        .cpu_cen(cen_v[1]), .stall(st_v[1]));
    jtframe_z80wait #(.DEVCNT(2), .RECOVERY(1), .CNTW(4), .M1WAIT(2)) dut_c (
        .rst(rst), .clk(clk), .cen_in(cen_in), .m1_n(m1_n), .mreq_n(mreq_n),
        .busak_n(busak_n), .rom_cs(rom_cs), .rom_ok(rom_ok), .dev_busy(dev_busy),
        .cpu_cen(cen_v[2]), .stall(st_v[2]));

    typedef struct packed {
        logic [2:0] cen;
        logic [2:0] st;
        logic       cin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state per configuration
    int       rec_cfg[3] = '{1, 0, 1};
    int       m1w_cfg[3] = '{0, 0, 2};
    bit [1:0] m_prev_cs[3];
    bit       m_fetch[3];
    int       m_wait[3];
    int       m_owed[3];
    bit       m_last[3];

    int  cyc = 0;
    bit  auto_cen = 1'b1;
    int  tot_cin = 0;
    int  tot_cen[3] = '{0, 0, 0};
    int  tot_st[3] = '{0, 0, 0};
    int  s_cin;
    int  s_cen[3];
    int  s_st[3];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_cycle(input int k, output bit ecen, output bit est);
        bit any_pend;
        bit halt;
        bit repay;
        bit fnow;
        if (rst) begin
            ecen = 1'b0;
            est = 1'b0;
            m_prev_cs[k] = 2'b00;
            m_fetch[k] = 1'b0;
            m_wait[k] = 0;
            m_owed[k] = 0;
            m_last[k] = 1'b0;
            return;
        end
        any_pend = 1'b0;
        for (int i = 0; i < 2; i++)
            if (rom_cs[i] && (!rom_ok[i] || !m_prev_cs[k][i])) any_pend = 1'b1;
        halt  = busak_n && (any_pend || dev_busy != 2'b00 || m_wait[k] > 0);
        repay = rec_cfg[k] == 1 && !cen_in && !halt && m_owed[k] > 0 && !m_last[k];
        ecen  = (cen_in && !halt) || repay;
        est   = halt;
        fnow  = !m1_n && !mreq_n;
        if (fnow && !m_fetch[k] && m1w_cfg[k] > 0) m_wait[k] = m1w_cfg[k];
        else if (cen_in && m_wait[k] > 0) m_wait[k] = m_wait[k] - 1;
        if (cen_in && halt && rec_cfg[k] == 1) m_owed[k] = (m_owed[k] < 15) ? m_owed[k] + 1 : 15;
        else if (repay) m_owed[k] = m_owed[k] - 1;
        m_last[k]    = ecen;
        m_fetch[k]   = fnow;
        m_prev_cs[k] = rom_cs;
    endtask

    // Inputs for this cycle are already set; predict, queue, then advance one clock.
    task automatic step();
        exp_t e;
        bit c;
        bit s;
        if (auto_cen) cen_in = (cyc % 4 == 0);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            model_cycle(k, c, s);
            e.cen[k] = c;
            e.st[k]  = s;
        end
        e.cin = cen_in;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align();
        while (cyc % 4 != 0) step();
    endtask

    task automatic snap();
        s_cin = tot_cin;
        for (int k = 0; k < 3; k++) begin
            s_cen[k] = tot_cen[k];
            s_st[k]  = tot_st[k];
        end
    endtask

    // Monitor: pop the prediction for this cycle and compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cpu_cen[%0d]", k), int'(cen_v[k]), int'(e.cen[k]));
                chk($sformatf("stall[%0d]", k), int'(st_v[k]), int'(e.st[k]));
                tot_cen[k] += int'(cen_v[k]);
                tot_st[k]  += int'(st_v[k]);
            end
            tot_cin += int'(e.cin);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset holds outputs low even with chip selects active
        rom_cs = 2'b11;
        snap();
        steps(4);
        chk("rst_cen_a", tot_cen[0] - s_cen[0], 0);
        chk("rst_stall_a", tot_st[0] - s_st[0], 0);
        rom_cs = 2'b00;
        rst = 1'b0;
        cyc = 0;
        steps(8);

        // rom_cs rising with rom_ok already high: one-clock stall, lost enable repaid
        rom_ok = 2'b01;
        align();
        snap();
        rom_cs = 2'b01;
        steps(12);
        rom_cs = 2'b00;
        steps(8);
        chk("stale_ok_stall_a", tot_st[0] - s_st[0], 1);
        chk("stale_ok_cen_a", tot_cen[0] - s_cen[0], tot_cin - s_cin);

        // three enables lost: repaid with recovery, dropped without
        align();
        snap();
        rom_ok = 2'b00;
        rom_cs = 2'b01;
        steps(12);
        rom_ok = 2'b01;
        steps(16);
        rom_cs = 2'b00;
        chk("repay_cen_a", tot_cen[0] - s_cen[0], tot_cin - s_cin);
        chk("drop_cen_b", tot_cen[1] - s_cen[1], tot_cin - s_cin - 3);

        // opcode fetch started off a cen clock: two enables held on dut c
        align();
        step();
        m1_n = 1'b0;
        mreq_n = 1'b0;
        snap();
        steps(12);
        chk("m1_stall_c", tot_st[2] - s_st[2], 7);
        chk("m1_cen_a", tot_cen[0] - s_cen[0], 3);
        m1_n = 1'b1;
        mreq_n = 1'b1;
        steps(4);
        // interrupt acknowledge must not add wait states
        m1_n = 1'b0;
        snap();
        steps(12);
        chk("inta_stall_c", tot_st[2] - s_st[2], 0);
        m1_n = 1'b1;
        steps(12);

        // 20 stalled enables: debt saturates at 15
        align();
        snap();
        dev_busy = 2'b10;
        steps(80);
        dev_busy = 2'b00;
        steps(80);
        chk("sat_cen_a", tot_cen[0] - s_cen[0], tot_cin - s_cin - 5);
        chk("sat_cen_b", tot_cen[1] - s_cen[1], tot_cin - s_cin - 20);

        // reset with outstanding debt: nothing repaid afterwards
        align();
        rom_ok = 2'b00;
        rom_cs = 2'b01;
        steps(20);
        rst = 1'b1;
        snap();
        steps(3);
        chk("rst_debt_cen_a", tot_cen[0] - s_cen[0], 0);
        rst = 1'b0;
        rom_cs = 2'b00;
        snap();
        steps(20);
        chk("post_rst_cen_a", tot_cen[0] - s_cen[0], tot_cin - s_cin);

        // bus released: no stall even with a pending device
        align();
        snap();
        rom_cs = 2'b01;
        busak_n = 1'b0;
        steps(8);
        chk("busak_stall_a", tot_st[0] - s_st[0], 0);
        chk("busak_cen_a", tot_cen[0] - s_cen[0], tot_cin - s_cin);
        busak_n = 1'b1;
        rom_cs = 2'b00;
        steps(8);

        // randomized traffic
        auto_cen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            cen_in   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) rom_cs = 2'($urandom);
            rom_ok   = 2'($urandom);
            dev_busy = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            busak_n  = ($urandom_range(0, 15) != 0);
            m1_n     = ($urandom_range(0, 1) == 0);
            mreq_n   = ($urandom_range(0, 1) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        cen_in = 1'b0;
        steps(2);
        chk("queue_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
